// File: rtl/mux_imm_sel_pkg.sv
// Shared datapath widths for the execute-stage operand selectors.
// DATA_WIDTH follows the project-wide `DATA_WIDTH define (32 if none is given).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mux_imm_sel_pkg;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int CNT_WIDTH  = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/mux_imm_sel_mux2_core.sv
// mux2_core: parameterised combinational 2:1 selector, y = sel ? b : a.
// Only a clean 1 on sel picks b; an unknown select falls through to a.
module mux2_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] y
);
  always_comb begin
    if (sel) y = b;
    else     y = a;
  end
endmodule

// File: rtl/mux_imm_sel.sv
// mux_imm_sel: ALU operand-B selector (register vs immediate) with a registered copy.
// Define MUX_IMM_SEL_STATS_EN to add saturating imm_cnt/reg_cnt selection counters.
module mux_imm_sel
  import mux_imm_sel_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_reg,
  input  logic [DATA_WIDTH-1:0] data_imm,
  input  logic                  use_imm,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] mux_out,
  output logic [DATA_WIDTH-1:0] mux_out_q,
  output logic                  out_valid
`ifdef MUX_IMM_SEL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  imm_cnt,
  output logic [CNT_WIDTH-1:0]  reg_cnt
`endif
);
  logic [DATA_WIDTH-1:0] mux_out_d, mux_out_qr;
  logic                  out_valid_d, out_valid_q;

  mux2_core #(.DATA_WIDTH(DATA_WIDTH)) u_mux2_core (
    .a   (data_reg),
    .b   (data_imm),
    .sel (use_imm),
    .y   (mux_out)
  );

  // Invalid cycles keep the last captured operand; only the valid flag drops.
  always_comb begin
    mux_out_d   = mux_out_qr;
    out_valid_d = 1'b0;
    if (in_valid) begin
      mux_out_d   = mux_out;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_out_qr  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mux_out_qr  <= mux_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mux_out_q = mux_out_qr;
  assign out_valid = out_valid_q;

`ifdef MUX_IMM_SEL_STATS_EN
  logic [CNT_WIDTH-1:0] imm_cnt_d, imm_cnt_q;
  logic [CNT_WIDTH-1:0] reg_cnt_d, reg_cnt_q;

  always_comb begin
    imm_cnt_d = imm_cnt_q;
    reg_cnt_d = reg_cnt_q;
    if (in_valid) begin
      if (use_imm) imm_cnt_d = sat_inc(imm_cnt_q);
      else         reg_cnt_d = sat_inc(reg_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_cnt_q <= '0;
      reg_cnt_q <= '0;
    end else begin
      imm_cnt_q <= imm_cnt_d;
      reg_cnt_q <= reg_cnt_d;
    end
  end

  assign imm_cnt = imm_cnt_q;
  assign reg_cnt = reg_cnt_q;
`endif
endmodule

// File: tb/tb_mux_imm_sel.sv
// Self-checking bench for mux_imm_sel: directed cases plus randomized traffic
// compared every cycle against a behavioural model (counters when MUX_IMM_SEL_STATS_EN).
module tb_mux_imm_sel;
  import mux_imm_sel_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DATA_WIDTH-1:0] data_reg, data_imm;
  logic                  use_imm, in_valid;
  logic [DATA_WIDTH-1:0] mux_out, mux_out_q;
  logic                  out_valid;
`ifdef MUX_IMM_SEL_STATS_EN
  logic [CNT_WIDTH-1:0]  imm_cnt, reg_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  logic [DATA_WIDTH-1:0] m_q;
  logic                  m_v;
  longint unsigned       m_imm, m_reg;
  bit                    model_ok = 1'b0;

  mux_imm_sel dut (
    .clk       (clk),
    .rst       (rst),
    .data_reg  (data_reg),
    .data_imm  (data_imm),
    .use_imm   (use_imm),
    .in_valid  (in_valid),
    .mux_out   (mux_out),
    .mux_out_q (mux_out_q),
    .out_valid (out_valid)
`ifdef MUX_IMM_SEL_STATS_EN
    ,
    .imm_cnt   (imm_cnt),
    .reg_cnt   (reg_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: what the spec says the registered outputs become after this edge.
  always @(posedge clk) begin
    if (rst) begin
      m_q = '0; m_v = 1'b0; m_imm = 0; m_reg = 0; model_ok = 1'b1;
    end else if (in_valid) begin
      m_q = (use_imm === 1'b1) ? data_imm : data_reg;
      m_v = 1'b1;
      if (use_imm === 1'b1) m_imm = (m_imm == 64'hFFFF_FFFF) ? m_imm : m_imm + 1;
      else                  m_reg = (m_reg == 64'hFFFF_FFFF) ? m_reg : m_reg + 1;
    end else begin
      m_v = 1'b0;
    end
  end

  // Compare process on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("mux_out_cyc", 64'(mux_out), 64'((use_imm === 1'b1) ? data_imm : data_reg));
    if (model_ok) begin
      check("out_valid_cyc", 64'(out_valid), 64'(m_v));
      check("mux_out_q_cyc", 64'(mux_out_q), 64'(m_q));
`ifdef MUX_IMM_SEL_STATS_EN
      check("imm_cnt_cyc", 64'(imm_cnt), m_imm);
      check("reg_cnt_cyc", 64'(reg_cnt), m_reg);
`endif
    end
  end

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input bit imm_sel,
                       input logic [DATA_WIDTH-1:0] dr, input logic [DATA_WIDTH-1:0] di);
    rst = r; in_valid = v; use_imm = imm_sel; data_reg = dr; data_imm = di;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 1, 999);
    #2;
    // Combinational path, before any clock edge.
    check("comb_imm_999", 64'(mux_out), 64'd999);
    use_imm = 1'b0; #1;
    check("comb_reg_1", 64'(mux_out), 64'd1);
    data_reg = 42; data_imm = 1000; use_imm = 1'b1; #1;
    check("comb_imm_1000", 64'(mux_out), 64'd1000);
    data_reg = '1; use_imm = 1'b0; #1;
    check("comb_full_width", 64'(mux_out), 64'hFFFF_FFFF);

    // Reset for two cycles with valid imm input held, then release.
    drive(1'b1, 1'b1, 1'b1, 0, 7);
    next_cycle;
    check("rst_valid0_a", 64'(out_valid), 64'd0);
    check("rst_q0_a", 64'(mux_out_q), 64'd0);
    next_cycle;
    check("rst_valid0_b", 64'(out_valid), 64'd0);
    check("rst_q0_b", 64'(mux_out_q), 64'd0);
    rst = 1'b0;
    next_cycle;
    check("post_rst_q7", 64'(mux_out_q), 64'd7);
    check("post_rst_valid", 64'(out_valid), 64'd1);

    // in_valid pattern 1,0,1 with register values 5,9,11.
    drive(1'b0, 1'b1, 1'b0, 5, 0);
    next_cycle;
    check("pat_q5", 64'(mux_out_q), 64'd5);
    check("pat_v1", 64'(out_valid), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 9, 0);
    next_cycle;
    check("pat_hold_q5", 64'(mux_out_q), 64'd5);
    check("pat_v0", 64'(out_valid), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 11, 0);
    next_cycle;
    check("pat_q11", 64'(mux_out_q), 64'd11);
    check("pat_v1b", 64'(out_valid), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 3, 77);
    next_cycle;
    check("rst_wins_v", 64'(out_valid), 64'd0);
    check("rst_wins_q", 64'(mux_out_q), 64'd0);

`ifdef MUX_IMM_SEL_STATS_EN
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 1'b1, 0, i + 1); next_cycle; end
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 1'b0, i + 1, 0); next_cycle; end
    drive(1'b0, 1'b0, 1'b1, 0, 0); next_cycle;
    check("stats_imm3", 64'(imm_cnt), 64'd3);
    check("stats_reg2", 64'(reg_cnt), 64'd2);
    drive(1'b1, 1'b0, 1'b0, 0, 0); next_cycle;
    check("stats_imm_clr", 64'(imm_cnt), 64'd0);
    check("stats_reg_clr", 64'(reg_cnt), 64'd0);
`endif

    // Randomized traffic, checked by the compare process each cycle.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            DATA_WIDTH'($urandom), DATA_WIDTH'($urandom));
      if (i % 40 == 0) data_imm = '1;
      if (i % 40 == 1) data_reg = '1;
      next_cycle;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
